// File: rtl/pic_host_bus_master_pkg.sv
// Shared definitions for the PIC host bus master: FSM state encodings,
// bus cycle types and small elaboration-time helpers.
package pic_host_bus_master_pkg;

  // Bus master FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_ACK1    = 3'd4,
    ST_GAP     = 3'd5,
    ST_ACK2    = 3'd6,
    ST_RECOVER = 3'd7
  } state_t;

  // Kind of bus cycle currently in flight
  typedef enum logic [1:0] {
    CYC_WRITE = 2'd0,
    CYC_READ  = 2'd1,
    CYC_INTA  = 2'd2
  } cyc_t;

  // Value parked on the data output whenever nothing is being written
  localparam logic [7:0] IDLE_DATA = 8'h00;

  // Largest of three cycle counts; sizes the shared down-counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold a reload value of maxv-1 (never less than one bit)
  function automatic int cnt_width(input int maxv);
    return (maxv <= 2) ? 1 : $clog2(maxv);
  endfunction

endpackage

// File: rtl/pic_host_bus_master_if.sv
// Host request/response, interrupt and PIC-side bus signals of the
// host bus master, bundled so the master and its environment share one view.
interface pic_host_bus_master_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_a0;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       int_ack_enable;
  logic       vector_valid;
  logic [7:0] vector;
  logic       busy;
  logic       chip_select_n;
  logic       read_enable_n;
  logic       write_enable_n;
  logic       interrupt_acknowledge_n;
  logic       A0;
  logic [7:0] data_bus_out;
  logic       data_bus_oe;
  logic [7:0] data_bus_in;
  logic       interrupt_to_cpu;

  // The bus master itself
  modport master (
    input  req_valid, req_write, req_a0, req_wdata, int_ack_enable,
           data_bus_in, interrupt_to_cpu,
    output req_ready, rsp_valid, rsp_rdata, vector_valid, vector, busy,
           chip_select_n, read_enable_n, write_enable_n,
           interrupt_acknowledge_n, A0, data_bus_out, data_bus_oe
  );

  // Host plus PIC environment around the master
  modport slave (
    output req_valid, req_write, req_a0, req_wdata, int_ack_enable,
           data_bus_in, interrupt_to_cpu,
    input  req_ready, rsp_valid, rsp_rdata, vector_valid, vector, busy,
           chip_select_n, read_enable_n, write_enable_n,
           interrupt_acknowledge_n, A0, data_bus_out, data_bus_oe
  );

endinterface

// File: rtl/pic_host_bus_master_sync2.sv
// Two-flop synchronizer bringing the asynchronous PIC INT line into the
// clock domain; both flops clear to 0 on reset.
module pic_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Shift the raw level through two flops to settle metastability
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pic_host_bus_master.sv
// CPU-side initiator for the 8259 PIC bus. Converts host register
// read/write requests into timed chip-select/RD/WR/A0 cycles and, when
// allowed, answers INT with an 8086-style two-pulse INTA sequence that
// captures the interrupt vector. All PIC-side outputs come from flops.
module pic_host_bus_master
  import pic_host_bus_master_pkg::*;
#(
  parameter int STROBE_CYCLES  = 2,
  parameter int GAP_CYCLES     = 1,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  pic_host_bus_master_if.master bus
);

  localparam int MAX_CYCLES = max3(STROBE_CYCLES, GAP_CYCLES, RECOVER_CYCLES);
  localparam int CNT_W      = cnt_width(MAX_CYCLES);

  localparam logic [CNT_W-1:0] STROBE_LOAD  = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);

  // Reject parameter values that would break the strobe timing
  if (STROBE_CYCLES < 1) begin : g_badStrobe
    $error("pic_host_bus_master: STROBE_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_badGap
    $error("pic_host_bus_master: GAP_CYCLES must be >= 1");
  end
  if (RECOVER_CYCLES < 2) begin : g_badRecover
    $error("pic_host_bus_master: RECOVER_CYCLES must cover the synchronizer depth");
  end

  state_t           r_state;
  cyc_t             r_cyc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_csN;
  logic             r_rdN;
  logic             r_wrN;
  logic             r_intaN;
  logic             r_a0;
  logic [7:0]       r_dataOut;
  logic             r_oe;
  logic [7:0]       r_rdCapture;
  logic             r_rspValid;
  logic [7:0]       r_rspData;
  logic             r_vecValid;
  logic [7:0]       r_vector;

  logic w_intSync;
  logic w_ackReq;
  logic w_cntDone;

  pic_sync2 u_intSync (
    .clock   (clock),
    .reset   (reset),
    .i_async (bus.interrupt_to_cpu),
    .o_sync  (w_intSync)
  );

  assign w_ackReq  = w_intSync && bus.int_ack_enable;
  assign w_cntDone = (r_cnt == '0);

  // An interrupt waiting to be acknowledged blocks new host requests, so
  // the INTA sequence always wins against a simultaneous request.
  assign bus.req_ready = (r_state == ST_IDLE) && !w_ackReq;
  assign bus.busy      = (r_state != ST_IDLE);

  assign bus.chip_select_n           = r_csN;
  assign bus.read_enable_n           = r_rdN;
  assign bus.write_enable_n          = r_wrN;
  assign bus.interrupt_acknowledge_n = r_intaN;
  assign bus.A0                      = r_a0;
  assign bus.data_bus_out            = r_dataOut;
  assign bus.data_bus_oe             = r_oe;
  assign bus.rsp_valid               = r_rspValid;
  assign bus.rsp_rdata               = r_rspData;
  assign bus.vector_valid            = r_vecValid;
  assign bus.vector                  = r_vector;

  // Bus cycle sequencer: one down-counter times every multi-clock state,
  // and every strobe, address and data output is updated here as a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cyc       <= CYC_WRITE;
      r_cnt       <= '0;
      r_csN       <= 1'b1;
      r_rdN       <= 1'b1;
      r_wrN       <= 1'b1;
      r_intaN     <= 1'b1;
      r_a0        <= 1'b0;
      r_dataOut   <= IDLE_DATA;
      r_oe        <= 1'b0;
      r_rdCapture <= 8'h00;
      r_rspValid  <= 1'b0;
      r_rspData   <= 8'h00;
      r_vecValid  <= 1'b0;
      r_vector    <= 8'h00;
    end else begin
      r_rspValid <= 1'b0;
      r_vecValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ackReq) begin
            r_state <= ST_ACK1;
            r_cyc   <= CYC_INTA;
            r_intaN <= 1'b0;
            r_cnt   <= STROBE_LOAD;
          end else if (bus.req_valid) begin
            r_state   <= ST_SETUP;
            r_cyc     <= bus.req_write ? CYC_WRITE : CYC_READ;
            r_csN     <= 1'b0;
            r_a0      <= bus.req_a0;
            r_oe      <= bus.req_write;
            r_dataOut <= bus.req_write ? bus.req_wdata : IDLE_DATA;
          end
        end
        ST_SETUP: begin
          r_state <= ST_STROBE;
          r_cnt   <= STROBE_LOAD;
          if (r_cyc == CYC_WRITE) r_wrN <= 1'b0;
          else                    r_rdN <= 1'b0;
        end
        ST_STROBE: begin
          if (w_cntDone) begin
            r_state <= ST_HOLD;
            r_wrN   <= 1'b1;
            r_rdN   <= 1'b1;
            if (r_cyc == CYC_READ) r_rdCapture <= bus.data_bus_in;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          r_state   <= ST_IDLE;
          r_csN     <= 1'b1;
          r_oe      <= 1'b0;
          r_a0      <= 1'b0;
          r_dataOut <= IDLE_DATA;
          if (r_cyc == CYC_READ) begin
            r_rspValid <= 1'b1;
            r_rspData  <= r_rdCapture;
          end
        end
        ST_ACK1: begin
          if (w_cntDone) begin
            r_state <= ST_GAP;
            r_intaN <= 1'b1;
            r_cnt   <= GAP_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (w_cntDone) begin
            r_state <= ST_ACK2;
            r_intaN <= 1'b0;
            r_cnt   <= STROBE_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_ACK2: begin
          if (w_cntDone) begin
            r_state    <= ST_RECOVER;
            r_intaN    <= 1'b1;
            r_vector   <= bus.data_bus_in;
            r_vecValid <= 1'b1;
            r_cnt      <= RECOVER_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RECOVER: begin
          if (w_cntDone) r_state <= ST_IDLE;
          else           r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Never drive the data bus while the PIC may be driving it
  a_oeVsStrobes: assert property (@(posedge clock) disable iff (reset)
    !(r_oe && (!r_rdN || !r_intaN)));

  // Read, write and interrupt-acknowledge strobes are mutually exclusive
  a_oneStrobe: assert property (@(posedge clock) disable iff (reset)
    ($countones({~r_rdN, ~r_wrN, ~r_intaN}) <= 1));

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Directed bench for pic_host_bus_master: a small PIC model answers reads
// and INTA pulses, a negedge monitor tallies strobe activity, and each
// scenario task checks the tallies against hand-computed values.
module tb_pic_host_bus_master;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pic_host_bus_master_if bus ();

  pic_host_bus_master #(
    .STROBE_CYCLES  (2),
    .GAP_CYCLES     (1),
    .RECOVER_CYCLES (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;

  // PIC model controls
  logic       intLine     = 1'b0;
  logic       intAutoDrop = 1'b0;
  logic [7:0] rdValue     = 8'hA5;
  logic [7:0] vecValue    = 8'h08;
  logic [7:0] expWData    = 8'h00;
  logic       expA0       = 1'b0;

  // Monitor tallies (written only by the monitor)
  int csLow, wrLow, rdLow, intaLow, intaPulses, gapHigh, curRun, maxRun;
  int oeCycles, dataBad, a0Bad, rspCount, vecCount, readyBusyBad, csBeforeVec;
  int oeBad = 0;
  int multiLow = 0;
  int clearSeq = 0;
  int lastClear = -1;
  logic prevInta = 1'b1;

  // PIC drops INT once it sees the second INTA pulse; it drives the read
  // value during RD and the vector during the second INTA pulse only.
  assign bus.interrupt_to_cpu = intLine && !(intAutoDrop && (intaPulses >= 2));
  assign bus.data_bus_in = !bus.read_enable_n ? rdValue :
                           (!bus.interrupt_acknowledge_n && (intaPulses >= 2)) ? vecValue : 8'hFF;

  // Sample the PIC-side outputs mid-cycle and tally strobe activity
  always @(negedge clock) begin
    if (clearSeq != lastClear) begin
      lastClear = clearSeq;
      csLow = 0; wrLow = 0; rdLow = 0; intaLow = 0; intaPulses = 0;
      gapHigh = 0; curRun = 0; maxRun = 0; oeCycles = 0; dataBad = 0;
      a0Bad = 0; rspCount = 0; vecCount = 0; readyBusyBad = 0; csBeforeVec = 0;
    end
    if (!bus.chip_select_n) begin
      csLow++;
      if (bus.A0 !== expA0) a0Bad++;
      if (vecCount == 0) csBeforeVec++;
    end
    if (!bus.write_enable_n) wrLow++;
    if (!bus.read_enable_n) rdLow++;
    if (!bus.interrupt_acknowledge_n) begin
      intaLow++;
      curRun++;
      if (prevInta) intaPulses++;
      if (curRun > maxRun) maxRun = curRun;
    end else begin
      curRun = 0;
      if (intaPulses == 1) gapHigh++;
    end
    prevInta = bus.interrupt_acknowledge_n;
    if (bus.data_bus_oe) begin
      oeCycles++;
      if (bus.data_bus_out !== expWData) dataBad++;
      if (!bus.read_enable_n || !bus.interrupt_acknowledge_n) oeBad++;
    end
    if ((int'(!bus.read_enable_n) + int'(!bus.write_enable_n) + int'(!bus.interrupt_acknowledge_n)) > 1) multiLow++;
    if (bus.rsp_valid) rspCount++;
    if (bus.vector_valid) vecCount++;
    if (bus.busy && bus.req_ready) readyBusyBad++;
  end

  // Ask the monitor to zero its tallies; returns on a negedge
  task automatic clearCounters();
    clearSeq++;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Present a request (called at a negedge) until it is accepted
  task automatic applyStimulus(input logic w, input logic a0, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_a0    = a0;
    bus.req_wdata = d;
    for (int i = 0; i < 200; i++) begin
      if (bus.req_ready) begin
        @(posedge clock);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    bus.req_valid = 1'b0;
    assertCount++;
    if (!ok) begin failCount++; $display("[TB] FAIL req_accept: accepted=%0d required=1", ok); end
  endtask

  // Wait (bounded) for the FSM to return to IDLE, then let pulses settle
  task automatic waitIdle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!bus.busy) begin done = 1'b1; break; end
    end
    assertCount++;
    if (!done) begin failCount++; $display("[TB] FAIL %s_idle: busy=%0b required=0", name, bus.busy); end
    waitCycles(2);
  endtask

  // Wait (bounded) for the monitor to see a vector_valid pulse
  task automatic waitVec(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (vecCount >= 1) begin done = 1'b1; break; end
    end
    assertCount++;
    if (!done) begin failCount++; $display("[TB] FAIL %s_vec_wait: vecCount=%0d required>=1", name, vecCount); end
  endtask

  task automatic test_reset();
    bit seen;
    reset = 1'b1;
    waitCycles(3);
    assertCount++; if (bus.chip_select_n !== 1'b1) begin failCount++; $display("[TB] FAIL rst_cs: got %0b required 1", bus.chip_select_n); end
    assertCount++; if (bus.read_enable_n !== 1'b1 || bus.write_enable_n !== 1'b1 || bus.interrupt_acknowledge_n !== 1'b1) begin failCount++; $display("[TB] FAIL rst_strobes: rd=%0b wr=%0b inta=%0b required 1/1/1", bus.read_enable_n, bus.write_enable_n, bus.interrupt_acknowledge_n); end
    assertCount++; if (bus.A0 !== 1'b0 || bus.data_bus_out !== 8'h00 || bus.data_bus_oe !== 1'b0) begin failCount++; $display("[TB] FAIL rst_bus: A0=%0b data=%0h oe=%0b required 0/00/0", bus.A0, bus.data_bus_out, bus.data_bus_oe); end
    assertCount++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.vector_valid !== 1'b0) begin failCount++; $display("[TB] FAIL rst_status: busy=%0b rsp=%0b vec=%0b required 0/0/0", bus.busy, bus.rsp_valid, bus.vector_valid); end
    assertCount++; if (bus.rsp_rdata !== 8'h00 || bus.vector !== 8'h00) begin failCount++; $display("[TB] FAIL rst_data: rdata=%0h vector=%0h required 00/00", bus.rsp_rdata, bus.vector); end
    reset = 1'b0;
    @(negedge clock);
    assertCount++; if (bus.req_ready !== 1'b1) begin failCount++; $display("[TB] FAIL rst_ready: got %0b required 1", bus.req_ready); end
    // Abort a read mid-strobe
    clearCounters();
    expA0 = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!bus.read_enable_n) begin seen = 1'b1; break; end
    end
    assertCount++; if (!seen) begin failCount++; $display("[TB] FAIL rst_mid_rd_seen: rd_low=%0b required 1", seen); end
    #2 reset = 1'b1;
    #1;
    assertCount++; if (bus.chip_select_n !== 1'b1 || bus.read_enable_n !== 1'b1 || bus.write_enable_n !== 1'b1 || bus.interrupt_acknowledge_n !== 1'b1) begin failCount++; $display("[TB] FAIL rst_mid_strobes: cs=%0b rd=%0b wr=%0b inta=%0b required all 1", bus.chip_select_n, bus.read_enable_n, bus.write_enable_n, bus.interrupt_acknowledge_n); end
    assertCount++; if (bus.data_bus_oe !== 1'b0 || bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL rst_mid_state: oe=%0b busy=%0b required 0/0", bus.data_bus_oe, bus.busy); end
    waitCycles(2);
    reset = 1'b0;
    @(negedge clock);
    assertCount++; if (bus.req_ready !== 1'b1) begin failCount++; $display("[TB] FAIL rst_mid_ready: got %0b required 1", bus.req_ready); end
    waitCycles(4);
    assertCount++; if (rspCount !== 0 || bus.rsp_rdata !== 8'h00) begin failCount++; $display("[TB] FAIL rst_mid_no_rsp: pulses=%0d rdata=%0h required 0/00", rspCount, bus.rsp_rdata); end
  endtask

  task automatic test_write();
    clearCounters();
    expWData = 8'h13;
    expA0    = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h13);
    waitIdle("wr");
    assertCount++; if (csLow !== 4) begin failCount++; $display("[TB] FAIL wr_cs_len: got %0d required 4", csLow); end
    assertCount++; if (wrLow !== 2) begin failCount++; $display("[TB] FAIL wr_strobe_len: got %0d required 2", wrLow); end
    assertCount++; if (oeCycles !== 4 || dataBad !== 0) begin failCount++; $display("[TB] FAIL wr_data: oe_cycles=%0d bad_data=%0d required 4/0", oeCycles, dataBad); end
    assertCount++; if (rdLow !== 0 || rspCount !== 0 || a0Bad !== 0) begin failCount++; $display("[TB] FAIL wr_side: rd=%0d rsp=%0d a0bad=%0d required 0/0/0", rdLow, rspCount, a0Bad); end
    assertCount++; if (readyBusyBad !== 0) begin failCount++; $display("[TB] FAIL wr_ready_busy: got %0d required 0", readyBusyBad); end
  endtask

  task automatic test_read();
    clearCounters();
    rdValue = 8'hA5;
    expA0   = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h00);
    waitIdle("rd");
    assertCount++; if (rdLow !== 2) begin failCount++; $display("[TB] FAIL rd_strobe_len: got %0d required 2", rdLow); end
    assertCount++; if (oeCycles !== 0) begin failCount++; $display("[TB] FAIL rd_oe: got %0d required 0", oeCycles); end
    assertCount++; if (rspCount !== 1) begin failCount++; $display("[TB] FAIL rd_rsp_pulses: got %0d required 1", rspCount); end
    assertCount++; if (bus.rsp_rdata !== 8'hA5) begin failCount++; $display("[TB] FAIL rd_rdata: got %0h required a5", bus.rsp_rdata); end
    assertCount++; if (csLow !== 4 || wrLow !== 0 || a0Bad !== 0) begin failCount++; $display("[TB] FAIL rd_cs: cs=%0d wr=%0d a0bad=%0d required 4/0/0", csLow, wrLow, a0Bad); end
  endtask

  task automatic test_inta();
    clearCounters();
    intAutoDrop = 1'b1;
    vecValue    = 8'h08;
    intLine     = 1'b1;
    waitVec("inta");
    waitCycles(12);
    assertCount++; if (intaPulses !== 2) begin failCount++; $display("[TB] FAIL inta_pulses: got %0d required 2", intaPulses); end
    assertCount++; if (intaLow !== 4 || maxRun !== 2) begin failCount++; $display("[TB] FAIL inta_width: low=%0d longest=%0d required 4/2", intaLow, maxRun); end
    assertCount++; if (gapHigh !== 1) begin failCount++; $display("[TB] FAIL inta_gap: got %0d required 1", gapHigh); end
    assertCount++; if (csLow !== 0 || oeCycles !== 0) begin failCount++; $display("[TB] FAIL inta_cs_oe: cs=%0d oe=%0d required 0/0", csLow, oeCycles); end
    assertCount++; if (vecCount !== 1 || bus.vector !== 8'h08) begin failCount++; $display("[TB] FAIL inta_vector: pulses=%0d vector=%0h required 1/08", vecCount, bus.vector); end
    intLine = 1'b0;
    waitCycles(3);
  endtask

  task automatic test_back_to_back();
    clearCounters();
    intAutoDrop = 1'b1;
    expWData    = 8'h5A;
    expA0       = 1'b1;
    intLine     = 1'b1;
    waitCycles(2);
    assertCount++; if (bus.req_ready !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_ready_blocked: got %0b required 0", bus.req_ready); end
    applyStimulus(1'b1, 1'b1, 8'h5A);
    waitIdle("b2b");
    assertCount++; if (vecCount !== 1 || intaPulses !== 2) begin failCount++; $display("[TB] FAIL b2b_inta: vec=%0d pulses=%0d required 1/2", vecCount, intaPulses); end
    assertCount++; if (csBeforeVec !== 0) begin failCount++; $display("[TB] FAIL b2b_order: cs_before_vector=%0d required 0", csBeforeVec); end
    assertCount++; if (csLow !== 4 || wrLow !== 2 || oeCycles !== 4 || dataBad !== 0 || a0Bad !== 0) begin failCount++; $display("[TB] FAIL b2b_write: cs=%0d wr=%0d oe=%0d bad=%0d a0bad=%0d required 4/2/4/0/0", csLow, wrLow, oeCycles, dataBad, a0Bad); end
    intLine = 1'b0;
    waitCycles(3);
    // INT with acknowledge disabled must be ignored
    clearCounters();
    intAutoDrop        = 1'b0;
    bus.int_ack_enable = 1'b0;
    intLine            = 1'b1;
    waitCycles(10);
    assertCount++; if (intaLow !== 0 || bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL noack_inta: low=%0d busy=%0b required 0/0", intaLow, bus.busy); end
    assertCount++; if (bus.req_ready !== 1'b1) begin failCount++; $display("[TB] FAIL noack_ready: got %0b required 1", bus.req_ready); end
    intLine            = 1'b0;
    bus.int_ack_enable = 1'b1;
    waitCycles(4);
  endtask

  task automatic test_reset_during_ack();
    bit seen;
    clearCounters();
    intAutoDrop = 1'b0;
    intLine     = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (!bus.interrupt_acknowledge_n) begin seen = 1'b1; break; end
    end
    assertCount++; if (!seen) begin failCount++; $display("[TB] FAIL rack_ack1_seen: got %0b required 1", seen); end
    #2 reset = 1'b1;
    #1;
    assertCount++; if (bus.interrupt_acknowledge_n !== 1'b1 || bus.busy !== 1'b0 || bus.chip_select_n !== 1'b1) begin failCount++; $display("[TB] FAIL rack_abort: inta=%0b busy=%0b cs=%0b required 1/0/1", bus.interrupt_acknowledge_n, bus.busy, bus.chip_select_n); end
    assertCount++; if (bus.vector_valid !== 1'b0 || bus.vector !== 8'h00) begin failCount++; $display("[TB] FAIL rack_vector_reset: valid=%0b vector=%0h required 0/00", bus.vector_valid, bus.vector); end
    clearCounters();
    intAutoDrop = 1'b1;
    reset = 1'b0;
    waitVec("rack");
    waitCycles(10);
    assertCount++; if (intaPulses !== 2 || intaLow !== 4 || maxRun !== 2 || gapHigh !== 1) begin failCount++; $display("[TB] FAIL rack_fresh_seq: pulses=%0d low=%0d longest=%0d gap=%0d required 2/4/2/1", intaPulses, intaLow, maxRun, gapHigh); end
    assertCount++; if (vecCount !== 1 || bus.vector !== 8'h08 || csLow !== 0) begin failCount++; $display("[TB] FAIL rack_vector: pulses=%0d vector=%0h cs=%0d required 1/08/0", vecCount, bus.vector, csLow); end
    intLine = 1'b0;
    waitCycles(3);
  endtask

  task automatic checkOutput();
    assertCount++; if (oeBad !== 0) begin failCount++; $display("[TB] FAIL inv_oe: got %0d required 0", oeBad); end
    assertCount++; if (multiLow !== 0) begin failCount++; $display("[TB] FAIL inv_one_strobe: got %0d required 0", multiLow); end
  endtask

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_a0         = 1'b0;
    bus.req_wdata      = 8'h00;
    bus.int_ack_enable = 1'b1;
    $display("[TB] starting pic_host_bus_master directed tests");
    test_reset();
    test_write();
    test_read();
    test_inta();
    test_back_to_back();
    test_reset_during_ack();
    checkOutput();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Global time limit in case the design stalls somewhere unexpected
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, failures so far %0d", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pic_host_bus_master.md
Name: pic_host_bus_master

Overview:
- CPU-side initiator for the 8259 PIC bus; the other end of the PIC's chip-select/RD/WR/A0/data/INTA interface.
- Turns simple host requests (register write/read) into correctly timed PIC bus cycles.
- Autonomously services INT with the 8086-style two-pulse INTA sequence and captures the vector byte.
- Used as the bus driver in PIC system benches and in SoC integration; the top level wraps the split data bus into the tristate data_bus.

Parameters:
- STROBE_CYCLES, 2, clocks that rd/wr/inta stay low per pulse (>=1; elaboration error otherwise).
- GAP_CYCLES, 1, clocks inta_n stays high between the two INTA pulses (>=1).
- RECOVER_CYCLES, 2, idle clocks after an INTA sequence before INT is re-sampled (>= synchronizer depth).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  host request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1=write cycle, 0=read cycle.
- req_a0  in  1  A0 value for the cycle.
- req_wdata  in  8  write data (ICW/OCW byte).
- rsp_valid  out  1  one-cycle pulse: read data available.
- rsp_rdata  out  8  captured read data; held until the next read completes.
- int_ack_enable  in  1  permits automatic INTA servicing.
- vector_valid  out  1  one-cycle pulse: vector captured.
- vector  out  8  captured vector; held until the next capture.
- busy  out  1  FSM not in IDLE.
- chip_select_n, read_enable_n, write_enable_n, interrupt_acknowledge_n  out  1 each  PIC strobes.
- A0  out  1  PIC address bit.
- data_bus_out  out  8  write data to PIC.
- data_bus_oe  out  1  drive enable for data_bus_out.
- data_bus_in  in  8  data from PIC.
- interrupt_to_cpu  in  1  PIC INT, asynchronous to clock.

Behaviour:
- Reset values: chip_select_n, read_enable_n, write_enable_n and interrupt_acknowledge_n = 1; A0 = 0; data_bus_out = 0; data_bus_oe = 0; rsp_valid and vector_valid = 0; rsp_rdata and vector = 0; busy = 0; FSM = IDLE; synchronizer flops = 0.
- Reset asserted mid-operation forces all of the above immediately. No rsp_valid or vector_valid is issued for the aborted cycle.
- All PIC-side outputs are registered (glitch-free strobes).
- interrupt_to_cpu passes through a 2-flop synchronizer; int_s is the synchronized level.
- req_ready = (state==IDLE) && !(int_s && int_ack_enable). After reset it is 1 once reset is released.
- FSM states:
  - IDLE.
  - SETUP: 1 cycle. cs_n=0; A0 driven; oe=1 and data driven if write.
  - STROBE: STROBE_CYCLES. wr_n or rd_n low.
  - HOLD: 1 cycle. Strobes high; cs_n, A0, data and oe held.
  - ACK1: STROBE_CYCLES. inta_n low.
  - GAP: GAP_CYCLES. inta_n high.
  - ACK2: STROBE_CYCLES. inta_n low.
  - RECOVER: RECOVER_CYCLES.
- IDLE priority: int_s && int_ack_enable goes to ACK1; otherwise an accepted request goes to SETUP. A simultaneous request waits (ack wins).
- Write cycle total: STROBE_CYCLES+2 clocks with cs_n low. Return to IDLE after HOLD.
- Read cycle: data_bus_in is sampled on the last STROBE clock. rsp_valid pulses in the clock after HOLD completes; oe stays 0 for the whole cycle.
- INTA sequence:
  - cs_n stays 1 and oe stays 0 throughout.
  - data_bus_in is sampled on the last ACK2 clock.
  - vector_valid pulses on entry to RECOVER.
  - RECOVER returns to IDLE with req_ready low; prevents re-acking a stale INT.
- If int_ack_enable drops during ACK1..ACK2, the sequence still completes (no half INTA).
- One down-counter sized to max(STROBE_CYCLES, GAP_CYCLES, RECOVER_CYCLES) times all states.
- Invariant (assertion): data_bus_oe never 1 while read_enable_n or interrupt_acknowledge_n is 0. At most one of rd_n, wr_n, inta_n low at any time.

Decomposition:
- Shared include pic_host_defs holds state encodings and cycle-type constants (CYC_WRITE, CYC_READ, CYC_INTA).
- One sub-module pic_sync2: 2-flop synchronizer with async active-high reset.

Test Plan:
1. Reset: assert reset mid-run -> all strobes = 1, oe = 0, busy = 0 in the same cycle. After release, req_ready = 1.
2. Write ICW1 0x13, A0=0, STROBE_CYCLES=2 -> cs_n low exactly 4 clocks, wr_n low exactly 2, data_bus_out = 0x13 with oe=1 for all 4. req_ready low until done.
3. Read IMR (A0=1), PIC model returns 0xA5 -> rd_n low 2 clocks, oe never 1, one rsp_valid pulse with rsp_rdata = 0xA5.
4. Raise INT; model drives 0x08 on the second pulse -> two 2-clock inta_n pulses separated by 1 high clock, cs_n=1, vector_valid one pulse, vector = 0x08, no re-ack while INT is low.
5. req_valid and INT rise on the same synchronized cycle -> INTA completes first. The request is accepted after RECOVER and a correct write follows; int_ack_enable=0 -> INT ignored, no inta_n activity.
6. Reset asserted during ACK1 -> inta_n returns to 1 immediately, no vector_valid. After release, a pending INT starts a fresh full two-pulse sequence.
